// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect and decode
// handshake signals of the fetch stage.
interface fetch_queue_if #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pcplus4;
    logic [OW-1:0]   occupancy;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc,
        output dec_pcplus4,
        output occupancy
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc,
        input  dec_pcplus4,
        input  occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC fetch with pipelined imem requests
// and a DEPTH-entry decoupling queue toward decode.
module fetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic reset,
    fetch_queue_if.master fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic            run;
    logic [XLEN-1:0] fetchPc;

    entry_t          queue [DEPTH];
    logic [AW-1:0]   rdPtr;
    logic [AW-1:0]   wrPtr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] tagPc [DEPTH];
    logic [AW-1:0]   tagRdPtr;
    logic [AW-1:0]   tagWrPtr;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;

    logic            reqFire;
    logic            rspValid;
    logic            enq;
    logic            deq;
    logic            redirect;
    logic [CW:0]     credit;

    // Queue slots and in-flight requests share one credit pool,
    // so a full queue can never be overrun by a late response.
    assign credit   = {1'b0, count} + {1'b0, outstanding};
    assign redirect = fq.redirect_valid;
    assign rspValid = fq.imem_rsp_valid;

    assign fq.imem_req_valid = run & ~redirect &
                               (credit < (CW+1)'(DEPTH));
    assign fq.imem_req_addr  = fetchPc;

    assign reqFire = fq.imem_req_valid & fq.imem_req_ready;
    assign enq     = rspValid & (dropCnt == '0) & ~redirect;
    assign deq     = (count != '0) & fq.dec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPc <= RESET_PC;
        end else if (redirect) begin
            fetchPc <= {fq.redirect_pc[XLEN-1:2], 2'b00};
        end else if (reqFire) begin
            fetchPc <= fetchPc + XLEN'(4);
        end
    end

    // Responses still owed for flushed requests are counted in
    // dropCnt and swallowed as they arrive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(rspValid);
            if (redirect) begin
                dropCnt <= outstanding - CW'(rspValid);
            end else if (rspValid && dropCnt != '0) begin
                dropCnt <= dropCnt - CW'(1);
            end
        end
    end

    // Every response pops a tag, dropped or not, keeping the
    // PC tags aligned with the in-order response stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagRdPtr <= '0;
            tagWrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tagPc[i] <= '0;
            end
        end else begin
            if (reqFire) begin
                tagPc[tagWrPtr] <= fetchPc;
                tagWrPtr        <= tagWrPtr + AW'(1);
            end
            if (rspValid) begin
                tagRdPtr <= tagRdPtr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue[i] <= '0;
            end
        end else if (redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                queue[wrPtr].instr <= fq.imem_rsp_data;
                queue[wrPtr].pc    <= tagPc[tagRdPtr];
                wrPtr              <= wrPtr + AW'(1);
            end
            if (deq) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign fq.dec_valid   = (count != '0);
    assign fq.dec_instr   = queue[rdPtr].instr;
    assign fq.dec_pc      = queue[rdPtr].pc;
    assign fq.dec_pcplus4 = queue[rdPtr].pc + XLEN'(4);
    assign fq.occupancy   = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against a
// fixed-latency in-order instruction memory model.
module tb_fetch_queue;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   memLat;
    int   nChecks;
    int   nPass;
    int   nReq;

    logic [3:0]      pipeV;
    logic [XLEN-1:0] pipeA [4];

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

    fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fq(fq.master)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers memLat cycles after acceptance, in order.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipeV <= '0;
            for (int i = 0; i < 4; i++) pipeA[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                pipeV[i] <= pipeV[i+1];
                pipeA[i] <= pipeA[i+1];
            end
            pipeV[3] <= 1'b0;
            pipeV[memLat-1] <= fq.imem_req_valid & fq.imem_req_ready;
            pipeA[memLat-1] <= fq.imem_req_addr;
        end
    end

    assign fq.imem_rsp_valid = pipeV[0];
    assign fq.imem_rsp_data  = memWord(pipeA[0]);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int lat, input logic rdy);
        reset = 1'b0;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc = '0;
        fq.dec_ready = rdy;
        memLat = lat;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic checkResetOuts(input string pfx);
        check({pfx, " reqv"}, 64'(fq.imem_req_valid), 64'd0);
        check({pfx, " addr"}, 64'(fq.imem_req_addr), 64'h0);
        check({pfx, " decv"}, 64'(fq.dec_valid), 64'd0);
        check({pfx, " instr"}, 64'(fq.dec_instr), 64'h0);
        check({pfx, " pc"}, 64'(fq.dec_pc), 64'h0);
        check({pfx, " pc4"}, 64'(fq.dec_pcplus4), 64'h4);
        check({pfx, " occ"}, 64'(fq.occupancy), 64'd0);
    endtask

    logic [31:0] drainPc [5];

    initial begin
        nChecks = 0;
        nPass = 0;
        reset = 1'b1;
        memLat = 1;
        fq.imem_req_ready = 1'b1;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc = '0;
        fq.dec_ready = 1'b1;
        drainPc[0] = 32'h0;
        drainPc[1] = 32'h4;
        drainPc[2] = 32'h8;
        drainPc[3] = 32'hC;
        drainPc[4] = 32'h10;

        // Reset release, 1-cycle memory, decode always ready
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOuts("rst");
        reset = 1'b1;
        #1;
        check("c0 reqv", 64'(fq.imem_req_valid), 64'd0);
        tick();
        check("c1 reqv", 64'(fq.imem_req_valid), 64'd1);
        check("c1 addr", 64'(fq.imem_req_addr), 64'h0);
        tick();
        check("c2 addr", 64'(fq.imem_req_addr), 64'h4);
        check("c2 decv", 64'(fq.dec_valid), 64'd0);
        tick();
        check("c3 decv", 64'(fq.dec_valid), 64'd1);
        check("c3 pc", 64'(fq.dec_pc), 64'h0);
        check("c3 instr", 64'(fq.dec_instr), 64'h1234_5678);
        check("c3 pc4", 64'(fq.dec_pcplus4), 64'h4);
        check("c3 occ", 64'(fq.occupancy), 64'd1);
        tick();
        check("c4 pc", 64'(fq.dec_pc), 64'h4);
        check("c4 pc4", 64'(fq.dec_pcplus4), 64'h8);
        tick();
        check("c5 decv", 64'(fq.dec_valid), 64'd1);
        check("c5 pc", 64'(fq.dec_pc), 64'h8);

        // Backpressure: queue fills, credit stops requests
        doReset(1, 1'b0);
        nReq = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (fq.imem_req_valid && fq.imem_req_ready) nReq++;
        end
        check("full nreq", 64'(nReq), 64'd4);
        check("full occ", 64'(fq.occupancy), 64'd4);
        check("full reqv", 64'(fq.imem_req_valid), 64'd0);
        check("full pc", 64'(fq.dec_pc), 64'h0);
        fq.dec_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            if (i == 1) begin
                check("resume addr", 64'(fq.imem_req_addr), 64'h10);
                check("resume reqv", 64'(fq.imem_req_valid), 64'd1);
            end
            check("drain decv", 64'(fq.dec_valid), 64'd1);
            check($sformatf("drain pc%0d", i),
                  64'(fq.dec_pc), 64'(drainPc[i]));
        end

        // Redirect with three requests in flight, 4-cycle memory
        doReset(4, 1'b1);
        tick(4);
        check("r3 pre reqv", 64'(fq.imem_req_valid), 64'd1);
        check("r3 pre addr", 64'(fq.imem_req_addr), 64'hC);
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h103;
        #1;
        check("r3 gate reqv", 64'(fq.imem_req_valid), 64'd0);
        tick();
        fq.redirect_valid = 1'b0;
        #1;
        check("r3 occ", 64'(fq.occupancy), 64'd0);
        check("r3 reqv", 64'(fq.imem_req_valid), 64'd1);
        check("r3 addr", 64'(fq.imem_req_addr), 64'h100);
        for (int c = 6; c <= 9; c++) begin
            tick();
            check($sformatf("r3 c%0d decv", c),
                  64'(fq.dec_valid), 64'd0);
        end
        tick();
        check("r3 decv", 64'(fq.dec_valid), 64'd1);
        check("r3 pc", 64'(fq.dec_pc), 64'h100);
        check("r3 instr", 64'(fq.dec_instr), 64'h1234_5778);

        // Redirect together with a response and a dequeue
        doReset(3, 1'b1);
        tick(5);
        check("r4 decv", 64'(fq.dec_valid), 64'd1);
        check("r4 pc", 64'(fq.dec_pc), 64'h0);
        check("r4 rsp", 64'(fq.imem_rsp_valid), 64'd1);
        check("r4 reqv", 64'(fq.imem_req_valid), 64'd0);
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'h200;
        tick();
        fq.redirect_valid = 1'b0;
        #1;
        check("r4 occ", 64'(fq.occupancy), 64'd0);
        check("r4 c6 decv", 64'(fq.dec_valid), 64'd0);
        check("r4 addr", 64'(fq.imem_req_addr), 64'h200);
        for (int c = 7; c <= 9; c++) begin
            tick();
            check($sformatf("r4 c%0d decv", c),
                  64'(fq.dec_valid), 64'd0);
        end
        tick();
        check("r4 new decv", 64'(fq.dec_valid), 64'd1);
        check("r4 new pc", 64'(fq.dec_pc), 64'h200);
        check("r4 new instr", 64'(fq.dec_instr), 64'h1234_5478);

        // PC wrap at the top of the address space
        doReset(1, 1'b1);
        tick();
        fq.redirect_valid = 1'b1;
        fq.redirect_pc = 32'hFFFF_FFFC;
        tick();
        fq.redirect_valid = 1'b0;
        #1;
        check("wrap addr0", 64'(fq.imem_req_addr), 64'hFFFF_FFFC);
        tick();
        check("wrap addr1", 64'(fq.imem_req_addr), 64'h0);
        tick();
        check("wrap pc", 64'(fq.dec_pc), 64'hFFFF_FFFC);
        check("wrap pc4", 64'(fq.dec_pcplus4), 64'h0);
        tick();
        check("wrap next pc", 64'(fq.dec_pc), 64'h0);
        check("wrap next pc4", 64'(fq.dec_pcplus4), 64'h4);

        // Asynchronous reset with the queue half full
        doReset(1, 1'b0);
        tick(4);
        check("mid occ", 64'(fq.occupancy), 64'd2);
        reset = 1'b0;
        #1;
        checkResetOuts("mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tick();
        check("mid c1 reqv", 64'(fq.imem_req_valid), 64'd1);
        check("mid c1 addr", 64'(fq.imem_req_addr), 64'h0);
        tick();
        check("mid c2 addr", 64'(fq.imem_req_addr), 64'h4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
